// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the instruction-fetch stage and its helpers:
//   XLEN              data / address width
//   RESET_PC_DEFAULT  default PC loaded on reset (word aligned)
//   NOP_INSTR         value presented on if_instr when nothing is held
//   if_state_t        fetch FSM state encoding
//   pc_align()        forces the two low PC bits to zero
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } if_state_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] i_pc);
    return i_pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// XLEN-wide 2:1 next-PC selector. Purely combinational; the fetch FSM decides
// when the selected value is actually loaded into the PC register.
// Ports:
//   i_sel          1     1 = take redirect target, 0 = sequential PC
//   i_redirect_pc  XLEN  redirect target (already word aligned by caller)
//   i_pc           XLEN  current PC
//   o_pc_next      XLEN  i_sel ? i_redirect_pc : i_pc + 4 (modulo 2^XLEN)
// ----------------------------------------------------------------------------
module pc_next_mux
  import core_pkg::*;
(
  input  logic            i_sel,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_pc_next
);

  logic [XLEN-1:0] w_pc_seq;

  assign w_pc_seq  = i_pc + 32'd4;
  assign o_pc_next = i_sel ? i_redirect_pc : w_pc_seq;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, issues one outstanding word request to
// instruction memory at a time and hands each fetched word, with its PC, to
// decode over a valid/ready handshake. A redirect from execute overrides
// everything; a request already in flight when the redirect lands is marked
// for discard so its data never reaches decode.
//
// Optional feature (macro IF_FETCH_CNT_EN): adds output fetch_cnt, a 32-bit
// wrapping count of decode transfers (if_valid && if_ready && !redirect_valid).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   redirect_valid/_pc         redirect strobe and target (bits [1:0] ignored)
//   imem_req/_addr             fetch request and word address (registered)
//   imem_gnt                   request accepted this cycle
//   imem_rvalid/_rdata         read response
//   if_valid/_pc/_instr        held instruction for decode
//   if_ready                   decode accepts the held instruction
//   fetch_cnt                  transfer count (IF_FETCH_CNT_EN only)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high with imem_addr = pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid (may be a discard)
// HOLD  | instruction held on if_*, waiting for decode to take it
// ----------------------------------------------------------------------------
module if_fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_cnt
`endif
);

  if_state_t       r_state;
  if_state_t       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_discard;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;

  logic [XLEN-1:0] w_redirect_aligned;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pc_load;
  logic            w_discard_nxt;
  logic            w_capture;
  logic            w_clear_instr;

  assign w_redirect_aligned = pc_align(redirect_pc);

  // Select follows the redirect strobe, so whenever the FSM loads the PC the
  // mux already presents the right source.
  pc_next_mux u_pc_next_mux (
    .i_sel         (redirect_valid),
    .i_redirect_pc (w_redirect_aligned),
    .i_pc          (r_pc),
    .o_pc_next     (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_load     = 1'b0;
    w_discard_nxt = r_discard;
    w_capture     = 1'b0;
    w_clear_instr = 1'b0;
    imem_req      = 1'b0;
    if_valid      = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        w_pc_load   = redirect_valid;
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          w_state_nxt = WAIT;
          // Old-address request is already in flight: remember to drop it.
          w_discard_nxt = redirect_valid;
          w_pc_load     = redirect_valid;
        end else begin
          w_pc_load = redirect_valid;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          w_discard_nxt = 1'b0;
          if (!r_discard && !redirect_valid) begin
            w_capture   = 1'b1;
            w_pc_load   = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_pc_load   = redirect_valid;
            w_state_nxt = REQ;
          end
        end else if (redirect_valid) begin
          w_pc_load     = 1'b1;
          w_discard_nxt = 1'b1;
        end
      end

      HOLD: begin
        if_valid = 1'b1;
        if (redirect_valid) begin
          w_pc_load     = 1'b1;
          w_clear_instr = 1'b1;
          w_state_nxt   = REQ;
        end else if (if_ready) begin
          w_clear_instr = 1'b1;
          w_state_nxt   = REQ;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_discard  <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP_INSTR;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_pc_next;
      end
      r_discard <= w_discard_nxt;
      if (w_capture) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rdata;
      end else if (w_clear_instr) begin
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  assign imem_addr = r_pc;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

`ifdef IF_FETCH_CNT_EN
  logic        w_xfer;
  logic [31:0] r_fetch_cnt;

  assign w_xfer = if_valid && if_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
    end else if (w_xfer) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
// Reactive memory/decode environment around if_fetch_stage. The stimulus side
// keeps a queue of PCs that decode should see next (sequential from the last
// redirect or reset target); a separate monitor pops that queue on every
// decode transfer and checks PC and instruction, plus protocol rules.
// Instruction memory content is a fixed function of the address.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit pct(input int p);
    return ($urandom_range(99, 0) < p);
  endfunction

  // Environment knobs
  int gnt_pct = 100, ready_pct = 100, redir_pct = 0, junk_pct = 0;
  int lat_min = 0, lat_max = 0;
  bit          inj_redir = 0;
  bit          inj_when_req = 0;
  logic [31:0] inj_target = '0;

  // Scoreboard: PCs decode must receive, in order
  logic [31:0] exp_pc_q[$];
  logic [31:0] next_push;

  task automatic sb_restart(input logic [31:0] t);
    exp_pc_q.delete();
    next_push = t & 32'hFFFF_FFFC;
  endtask

  task automatic sb_fill();
    while (exp_pc_q.size() < 16) begin
      exp_pc_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endtask

  // ---------------- stimulus / memory responder ----------------
  bit          out_busy, prev_req, prev_gnt;
  int          out_cnt;
  logic [31:0] out_addr, prev_addr;

  initial begin
    redirect_valid = 0; redirect_pc = '0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = '0; if_ready = 0; out_busy = 0; prev_req = 0; prev_gnt = 0;
    out_cnt = 0; out_addr = '0; prev_addr = '0;
    sb_restart(RESET_PC_DEFAULT);
    sb_fill();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; if_ready = 0;
        out_busy = 0; prev_req = 0; prev_gnt = 0;
        sb_restart(RESET_PC_DEFAULT);
        sb_fill();
      end else begin
        if (prev_req && prev_gnt) begin
          out_busy = 1;
          out_cnt  = $urandom_range(lat_max, lat_min);
          out_addr = prev_addr;
        end
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (out_busy) begin
          if (out_cnt == 0) begin
            imem_rvalid = 1;
            imem_rdata  = mem_word(out_addr);
            out_busy    = 0;
          end else begin
            out_cnt--;
          end
        end else if (!if_valid && pct(junk_pct)) begin
          // Stray response while the stage is idle or requesting: must be ignored
          imem_rvalid = 1;
          imem_rdata  = ~mem_word(imem_addr);
        end
        imem_gnt       = pct(gnt_pct);
        redirect_valid = 0;
        if (inj_redir && (!inj_when_req || imem_req)) begin
          redirect_valid = 1;
          redirect_pc    = inj_target;
          if (inj_when_req) imem_gnt = 1;
          inj_redir = 0;
        end else if (pct(redir_pct)) begin
          redirect_valid = 1;
          case ($urandom_range(3, 0))
            0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            1:       redirect_pc = $urandom & 32'h0000_00FF;
            default: redirect_pc = $urandom;
          endcase
        end
        if (redirect_valid) sb_restart(redirect_pc);
        sb_fill();
        if_ready  = pct(ready_pct);
        prev_req  = imem_req;
        prev_gnt  = imem_gnt;
        prev_addr = imem_addr;
      end
    end
  end

  // ---------------- monitor ----------------
  int          pending;
  bit          m_valid, m_ready, m_redir, m_req, m_gnt;
  logic [31:0] m_addr, m_pc, m_instr;
  logic [31:0] exp_cnt;

  initial begin
    pending = 0; m_valid = 0; m_ready = 0; m_redir = 0; m_req = 0; m_gnt = 0;
    m_addr = '0; m_pc = '0; m_instr = '0; exp_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0; m_valid = 0; m_redir = 0; m_req = 0; m_gnt = 0;
        exp_cnt = '0;
      end else begin
        if (if_valid && if_ready && !redirect_valid) begin
          if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected: got pc %h with no expected entry", if_pc);
          end else begin
            logic [31:0] e;
            e = exp_pc_q.pop_front();
            check("xfer_pc", if_pc, e);
            check("xfer_instr", if_instr, mem_word(e));
          end
        end
        if (!if_valid) check("empty_instr_nop", if_instr, NOP_INSTR);
        if (imem_req) begin
          check1("req_not_in_hold", if_valid, 1'b0);
          check("single_outstanding", 32'(pending), 32'd0);
          check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
        end
        if (m_valid && !m_ready && !m_redir) begin
          check1("hold_valid_kept", if_valid, 1'b1);
          check("hold_pc_stable", if_pc, m_pc);
          check("hold_instr_stable", if_instr, m_instr);
        end
        if (m_req && !m_gnt && !m_redir) begin
          check1("req_kept", imem_req, 1'b1);
          check("addr_stable", imem_addr, m_addr);
        end
`ifdef IF_FETCH_CNT_EN
        check("fetch_cnt", fetch_cnt, exp_cnt);
        if (if_valid && if_ready && !redirect_valid) exp_cnt = exp_cnt + 32'd1;
`endif
        if (imem_req && imem_gnt) pending++;
        if (imem_rvalid && pending > 0) pending--;
        m_valid = if_valid; m_ready = if_ready; m_redir = redirect_valid;
        m_req = imem_req; m_gnt = imem_gnt; m_addr = imem_addr;
        m_pc = if_pc; m_instr = if_instr;
      end
    end
  end

  // ---------------- directed sequence, then random ----------------
  task automatic wait_valid(input string n);
    int k = 0;
    while (!if_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check1({n, "_valid_timeout"}, if_valid, 1'b1);
  endtask

  task automatic wait_req(input string n);
    int k = 0;
    while (!imem_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    check1({n, "_req_timeout"}, imem_req, 1'b1);
  endtask

  task automatic wait_redirect(input string n);
    int k = 0;
    while (!redirect_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check1({n, "_redirect_timeout"}, redirect_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string n);
    check1({n, "_req"}, imem_req, 1'b0);
    check({n, "_addr"}, imem_addr, RESET_PC_DEFAULT);
    check1({n, "_valid"}, if_valid, 1'b0);
    check({n, "_pc"}, if_pc, 32'h0);
    check({n, "_instr"}, if_instr, NOP_INSTR);
  endtask

  initial begin
    logic [31:0] hpc, hinstr, cnt_before;
    rst_n = 0;
    cnt_before = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    // Reset release: IDLE, REQ, WAIT (rvalid), HOLD, next REQ at PC 4
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk); check1("first_cycle_idle", imem_req, 1'b0);
    @(negedge clk); check1("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk); check1("wait_no_req", imem_req, 1'b0);
    @(negedge clk); check1("first_valid", if_valid, 1'b1);
    check("first_if_pc", if_pc, 32'h0);
    @(negedge clk); check1("second_req", imem_req, 1'b1);
    check("second_addr", imem_addr, 32'h4);
    @(negedge clk);
    @(negedge clk); check1("three_cycle_valid", if_valid, 1'b1);
    check("three_cycle_pc", if_pc, 32'h4);

    // Decode stalls for 5 cycles
    ready_pct = 0;
    @(negedge clk);
    wait_valid("stall");
    hpc = if_pc; hinstr = if_instr;
    repeat (5) begin
      @(negedge clk);
      check1("stall_valid", if_valid, 1'b1);
      check("stall_pc", if_pc, hpc);
      check("stall_instr", if_instr, hinstr);
      check1("stall_no_req", imem_req, 1'b0);
    end
    ready_pct = 100;

    // Redirect to 0x100 while waiting; response arrives two cycles after gnt
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    wait_req("wait_redir");
    inj_target = 32'h0000_0100; inj_when_req = 0; inj_redir = 1;
    @(negedge clk); check1("wait_redir_seen", redirect_valid, 1'b1);
    check1("wait_redir_no_valid", if_valid, 1'b0);
    @(negedge clk); check1("wait_redir_drop_valid", if_valid, 1'b0);
    check1("wait_redir_drop_rvalid", imem_rvalid, 1'b1);
    @(negedge clk); check1("wait_redir_req", imem_req, 1'b1);
    check("wait_redir_addr", imem_addr, 32'h0000_0100);
    check1("wait_redir_still_no_valid", if_valid, 1'b0);

    // Redirect to 0x203 coincident with gnt in REQ
    inj_target = 32'h0000_0203; inj_when_req = 1; inj_redir = 1;
    @(negedge clk);
    wait_redirect("req_redir");
    check1("req_redir_gnt", imem_gnt, 1'b1);
    repeat (2) begin
      @(negedge clk); check1("req_redir_no_valid", if_valid, 1'b0);
    end
    @(negedge clk); check1("req_redir_req", imem_req, 1'b1);
    check("req_redir_addr", imem_addr, 32'h0000_0200);
    inj_when_req = 0;

    // Redirect in HOLD with if_ready high (no transfer), target wraps
    ready_pct = 0;
    @(negedge clk);
    wait_valid("hold_redir");
    inj_target = 32'hFFFF_FFFC; inj_redir = 1; ready_pct = 100;
`ifdef IF_FETCH_CNT_EN
    cnt_before = fetch_cnt;
`endif
    @(negedge clk); check1("hold_redir_seen", redirect_valid, 1'b1);
    check1("hold_redir_ready", if_ready, 1'b1);
    @(negedge clk); check1("hold_redir_invalid", if_valid, 1'b0);
`ifdef IF_FETCH_CNT_EN
    check("hold_redir_cnt", fetch_cnt, cnt_before);
`endif
    wait_valid("wrap");
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    wait_req("wrap");
    check("wrap_next_addr", imem_addr, 32'h0);

    // Asynchronous reset in HOLD
    ready_pct = 0;
    wait_valid("rst_hold");
    @(posedge clk);
    #3 rst_n = 0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    ready_pct = 100;
    @(negedge clk);
    wait_req("post_reset");
    check("post_reset_addr", imem_addr, RESET_PC_DEFAULT);

    // Random traffic
    gnt_pct = 70; ready_pct = 70; redir_pct = 10; junk_pct = 15;
    lat_min = 0; lat_max = 3;
    repeat (4000) @(negedge clk);
    redir_pct = 0; junk_pct = 0; ready_pct = 100; gnt_pct = 100;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
